// File: rtl/apb_spi_slave.sv
// -----------------------------------------------------------------------------
// apb_spi_slave
//
// APB3-programmable SPI target. SCLK, CS_n and MOSI are oversampled in the
// pclk domain. Received words land in an RX register; MISO is driven from a
// TX holding register. All four CPOL/CPHA modes, MSB/LSB-first ordering and
// word widths of 1..32 bits are supported. Several words may be exchanged
// back-to-back within one CS_n assertion.
//
// Register map (paddr[7:2]):
//   0x00 CTRL   [0]en [1]cpol [2]cpha [3]msb_first [12:8]dw_m1 (width-1)
//   0x04 TX     write loads tx_hold and sets tx_full; read returns tx_hold
//   0x08 RX     read returns rx_reg and clears rx_valid
//   0x0C STS    [0]busy [1]rx_valid [2]tx_full [3]rx_overrun [4]tx_underrun
//               (bits 3/4 sticky, write-1-to-clear)
//   0x10 IRQ_EN [0]rx_valid [1]overrun [2]underrun
//
// Ports:
//   pclk, presetn             APB clock, async active-low reset
//   psel/penable/pwrite       APB3 control
//   paddr[7:0], pwdata[31:0]  APB address / write data
//   prdata[31:0]              APB read data (combinational mux)
//   pready, pslverr           zero-wait ready, error on unmapped address
//   spi_sclk/spi_cs_n/spi_mosi  SPI bus from the external master (async)
//   spi_miso, spi_miso_oe     serial data out and pad output enable
//   irq                       level interrupt, OR of enabled status bits
// -----------------------------------------------------------------------------
module apb_spi_slave #(
  parameter int unsigned DATA_WIDTH_DEFAULT = 8,
  parameter bit          MSB_FIRST_DEFAULT  = 1'b1
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  localparam logic [5:0] A_CTRL = 6'd0;
  localparam logic [5:0] A_TX   = 6'd1;
  localparam logic [5:0] A_RX   = 6'd2;
  localparam logic [5:0] A_STS  = 6'd3;
  localparam logic [5:0] A_IE   = 6'd4;

  localparam logic [4:0] DW_M1_RST = 5'(DATA_WIDTH_DEFAULT - 1);

  // ---------------------------------------------------------------------------
  // APB decode
  // ---------------------------------------------------------------------------
  logic [5:0] addr_idx;
  logic       apb_wr, apb_rd;
  logic       ctrl_wr, tx_wr, sts_wr, ie_wr, rx_rd;
  logic       unused_addr_bits;

  assign addr_idx = paddr[7:2];
  assign apb_wr   = psel & penable & pwrite;
  assign apb_rd   = psel & penable & ~pwrite;
  assign ctrl_wr  = apb_wr && (addr_idx == A_CTRL);
  assign tx_wr    = apb_wr && (addr_idx == A_TX);
  assign sts_wr   = apb_wr && (addr_idx == A_STS);
  assign ie_wr    = apb_wr && (addr_idx == A_IE);
  assign rx_rd    = apb_rd && (addr_idx == A_RX);

  // Byte offset bits are don't-care for a word-aligned map.
  assign unused_addr_bits = ^paddr[1:0];

  assign pready  = psel;
  assign pslverr = psel & penable & (addr_idx > A_IE);

  // ---------------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------------
  logic        ctrl_en, ctrl_cpol, ctrl_cpha, ctrl_msb;
  logic [4:0]  ctrl_dw_m1;
  logic [31:0] tx_hold, rx_reg;
  logic        tx_full, rx_valid, rx_overrun, tx_underrun;
  logic [2:0]  irq_en;

  // ---------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizers, then a registered edge detector
  // so the edge pulses are one clean pclk wide.
  // ---------------------------------------------------------------------------
  logic sclk_meta, sclk_sync, sclk_prev;
  logic cs_meta, cs_sync, cs_prev;
  logic mosi_meta, mosi_sync;
  logic lead_edge, trail_edge, cs_fall;

  // NOTE: every clocked block uses non-blocking assignments so all flops
  // sample the pre-edge values; blocking here would collapse the synchronizer.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sclk_meta  <= 1'b0;
      sclk_sync  <= 1'b0;
      sclk_prev  <= 1'b0;
      cs_meta    <= 1'b1;
      cs_sync    <= 1'b1;
      cs_prev    <= 1'b1;
      mosi_meta  <= 1'b0;
      mosi_sync  <= 1'b0;
      lead_edge  <= 1'b0;
      trail_edge <= 1'b0;
      cs_fall    <= 1'b0;
    end else begin
      sclk_meta  <= spi_sclk;
      sclk_sync  <= sclk_meta;
      sclk_prev  <= sclk_sync;
      cs_meta    <= spi_cs_n;
      cs_sync    <= cs_meta;
      cs_prev    <= cs_sync;
      mosi_meta  <= spi_mosi;
      mosi_sync  <= mosi_meta;
      // Leading edge moves SCLK away from its idle level (cpol).
      lead_edge  <= (sclk_sync != sclk_prev) && (sclk_sync != ctrl_cpol);
      trail_edge <= (sclk_sync != sclk_prev) && (sclk_sync == ctrl_cpol);
      cs_fall    <= cs_prev & ~cs_sync;
    end
  end

  // ---------------------------------------------------------------------------
  // Shift datapath control signals
  // ---------------------------------------------------------------------------
  state_t      state, state_nxt;
  logic [31:0] tx_shift, rx_shift;
  logic [5:0]  bit_cnt;
  logic        miso_bit;
  logic        first_chg;    // next change edge re-drives instead of advancing
  logic        frame_first;  // next LOAD opens a new CS_n frame

  logic        sample_edge, change_edge, abort, last_bit, word_done, load;
  logic [31:0] load_val, tx_adv, rx_next;
  logic        load_bit, adv_bit, hold_bit;

  assign sample_edge = ctrl_cpha ? trail_edge : lead_edge;
  assign change_edge = ctrl_cpha ? lead_edge  : trail_edge;
  assign abort       = cs_sync | ~ctrl_en;
  assign last_bit    = (bit_cnt == {1'b0, ctrl_dw_m1});
  assign word_done   = (state == ST_SHIFT) && !abort && sample_edge && last_bit;
  assign load        = (state == ST_LOAD);

  // A TX write coinciding with LOAD bypasses straight into the shifter.
  assign load_val = tx_wr ? pwdata : (tx_full ? tx_hold : 32'd0);
  assign load_bit = ctrl_msb ? load_val[ctrl_dw_m1] : load_val[0];

  assign tx_adv   = ctrl_msb ? (tx_shift << 1) : (tx_shift >> 1);
  assign adv_bit  = ctrl_msb ? tx_adv[ctrl_dw_m1] : tx_adv[0];
  assign hold_bit = ctrl_msb ? tx_shift[ctrl_dw_m1] : tx_shift[0];

  // MSB-first shifts in at bit 0; LSB-first inserts at the top of the word so
  // the finished value is right-justified either way (shifter cleared at LOAD).
  assign rx_next = ctrl_msb ? {rx_shift[30:0], mosi_sync}
                            : ((rx_shift >> 1) | (32'(mosi_sync) << ctrl_dw_m1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM: next state
  // NOTE: combinational blocks assign a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (cs_fall && ctrl_en) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (abort)          state_nxt = ST_IDLE;
        else if (word_done) state_nxt = ST_LOAD;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    spi_miso_oe = 1'b0;
    spi_miso    = 1'b0;
    if (state != ST_IDLE) begin
      spi_miso_oe = 1'b1;
      spi_miso    = miso_bit;
    end
  end

  // ---------------------------------------------------------------------------
  // Shift datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      miso_bit    <= 1'b0;
      first_chg   <= 1'b0;
      frame_first <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          bit_cnt     <= '0;
          miso_bit    <= 1'b0;
          first_chg   <= 1'b0;
          frame_first <= 1'b1;
        end
        ST_LOAD: begin
          tx_shift    <= load_val;
          rx_shift    <= '0;
          bit_cnt     <= '0;
          frame_first <= 1'b0;
          // With cpha=1 the first change edge presents bit 0. With cpha=0 a
          // follow-on word already has bit 0 on the line, so the trailing edge
          // of the previous word's last bit must not advance it.
          first_chg   <= ctrl_cpha | ~frame_first;
          if (!ctrl_cpha) miso_bit <= load_bit;
        end
        ST_SHIFT: begin
          if (sample_edge) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt + 6'd1;
          end
          if (change_edge) begin
            if (first_chg) begin
              first_chg <= 1'b0;
              miso_bit  <= hold_bit;
            end else begin
              tx_shift  <= tx_adv;
              miso_bit  <= adv_bit;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register file. Where a hardware set event coincides with a software
  // clear, the set wins.
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ctrl_en     <= 1'b0;
      ctrl_cpol   <= 1'b0;
      ctrl_cpha   <= 1'b0;
      ctrl_msb    <= MSB_FIRST_DEFAULT;
      ctrl_dw_m1  <= DW_M1_RST;
      tx_hold     <= '0;
      tx_full     <= 1'b0;
      rx_reg      <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      irq_en      <= '0;
    end else begin
      if (ctrl_wr) begin
        ctrl_en    <= pwdata[0];
        ctrl_cpol  <= pwdata[1];
        ctrl_cpha  <= pwdata[2];
        ctrl_msb   <= pwdata[3];
        ctrl_dw_m1 <= pwdata[12:8];
      end

      if (tx_wr) tx_hold <= pwdata;

      // LOAD always empties the holding register; a same-cycle write went
      // straight into the shifter and so leaves it empty too.
      if (load)       tx_full <= 1'b0;
      else if (tx_wr) tx_full <= 1'b1;

      if (load && !tx_full && !tx_wr)  tx_underrun <= 1'b1;
      else if (sts_wr && pwdata[4])    tx_underrun <= 1'b0;

      if (word_done) rx_reg <= rx_next;

      // A read in the completion cycle returns the old word and counts as
      // having consumed it, so it does not flag an overrun.
      if (word_done && rx_valid && !rx_rd) rx_overrun <= 1'b1;
      else if (sts_wr && pwdata[3])        rx_overrun <= 1'b0;

      if (word_done)  rx_valid <= 1'b1;
      else if (rx_rd) rx_valid <= 1'b0;

      if (ie_wr) irq_en <= pwdata[2:0];
    end
  end

  assign irq = (rx_valid & irq_en[0]) | (rx_overrun & irq_en[1]) |
               (tx_underrun & irq_en[2]);

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    prdata = '0;
    unique case (addr_idx)
      A_CTRL: prdata = {19'd0, ctrl_dw_m1, 4'd0, ctrl_msb, ctrl_cpha,
                        ctrl_cpol, ctrl_en};
      A_TX:   prdata = tx_hold;
      A_RX:   prdata = rx_reg;
      A_STS:  prdata = {27'd0, tx_underrun, rx_overrun, tx_full, rx_valid,
                        (state != ST_IDLE)};
      A_IE:   prdata = {29'd0, irq_en};
      default: prdata = '0;
    endcase
  end

endmodule

// File: tb/tb_apb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_spi_slave
//
// Drives apb_spi_slave as an APB master and as an external SPI master. The
// reference model tracks the register state at transaction level: each CS_n
// frame is a LOAD, then per completed word one RX update followed by another
// LOAD. Directed frames cover the basic modes and corner cases, followed by
// randomized frames.
// -----------------------------------------------------------------------------
module tb_apb_spi_slave;

  localparam int HALF = 6;  // SCLK half period in pclk cycles

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe, irq;

  apb_spi_slave dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .irq         (irq)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;

  // Model state
  logic [31:0] m_tx_hold, m_rx;
  logic        m_tx_full, m_rv, m_ovr, m_und;
  logic [2:0]  m_ie;

  // Current bus configuration and frame bookkeeping
  logic        c_cpol, c_cpha, c_msb;
  int          c_w;
  logic [31:0] tx_words[$];
  logic [31:0] rcv_words[$];
  logic [31:0] exp_out[$];
  logic [31:0] acc;
  logic        last_err, last_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wmask(input int w);
    logic [63:0] one = 64'd1;
    return 32'((one << w) - 64'd1);
  endfunction

  // ---------------------------------------------------------------- APB ----
  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge pclk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge pclk); penable = 1'b1;
    @(negedge pclk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge pclk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge pclk); penable = 1'b1;
    #1; d = prdata; last_err = pslverr; last_rdy = pready;
    @(negedge pclk); psel = 1'b0; penable = 1'b0;
  endtask

  // -------------------------------------------------------------- model ----
  task automatic model_reset();
    m_tx_hold = '0; m_rx = '0; m_tx_full = 0; m_rv = 0; m_ovr = 0; m_und = 0; m_ie = '0;
  endtask

  // Start of a word: take the held TX value or underrun with zeros.
  task automatic model_load(output logic [31:0] v);
    if (m_tx_full) begin v = m_tx_hold; m_tx_full = 1'b0; end
    else begin v = '0; m_und = 1'b1; end
  endtask

  // ---------------------------------------------------------- SPI master ----
  function automatic logic mbit(input int k);
    logic [31:0] wd;
    int i;
    wd = tx_words[k / c_w];
    i  = k % c_w;
    return c_msb ? wd[c_w-1-i] : wd[i];
  endfunction

  task automatic capture(input int k, input logic b);
    int i;
    i = k % c_w;
    if (i == 0) acc = '0;
    if (c_msb) acc = (acc << 1) | 32'(b);
    else       acc[i] = b;
    if (i == c_w - 1) rcv_words.push_back(acc);
  endtask

  // Exchange nwords words, or only stop_after bits when stop_after > 0.
  task automatic spi_xfer(input int nwords, input int stop_after);
    int nb;
    nb = (stop_after > 0) ? stop_after : nwords * c_w;
    rcv_words.delete();
    @(negedge pclk); spi_cs_n = 1'b0;
    if (!c_cpha) spi_mosi = mbit(0);
    repeat (8) @(negedge pclk);
    for (int k = 0; k < nb; k++) begin
      if (c_cpha) begin
        spi_sclk = ~c_cpol; spi_mosi = mbit(k);
        repeat (HALF) @(negedge pclk);
        capture(k, spi_miso); spi_sclk = c_cpol;
        repeat (HALF) @(negedge pclk);
      end else begin
        capture(k, spi_miso); spi_sclk = ~c_cpol;
        repeat (HALF) @(negedge pclk);
        spi_sclk = c_cpol;
        if (k + 1 < nb) spi_mosi = mbit(k + 1);
        repeat (HALF) @(negedge pclk);
      end
    end
    repeat (10) @(negedge pclk); spi_cs_n = 1'b1;
    repeat (8) @(negedge pclk);
  endtask

  // Configure, optionally load TX, predict, run the frame and compare what
  // the master received. tx_words must already hold the words to send.
  task automatic run_frame(input string tag, input logic cpol, input logic cpha,
                           input logic msb, input int w, input int nwords,
                           input int stop_after, input logic do_tx,
                           input logic [31:0] txv);
    logic [31:0] cur, mask;
    int ncomp;
    c_cpol = cpol; c_cpha = cpha; c_msb = msb; c_w = w;
    mask = wmask(w);
    @(negedge pclk); spi_sclk = cpol;
    apb_write(8'h00, {19'd0, 5'(w - 1), 4'd0, msb, cpha, cpol, 1'b1});
    if (do_tx) begin
      apb_write(8'h04, txv);
      m_tx_hold = txv; m_tx_full = 1'b1;
    end
    exp_out.delete();
    ncomp = (stop_after > 0) ? 0 : nwords;
    model_load(cur);
    for (int i = 0; i < ncomp; i++) begin
      exp_out.push_back(cur & mask);
      if (m_rv) m_ovr = 1'b1;
      m_rx = tx_words[i] & mask;
      m_rv = 1'b1;
      model_load(cur);
    end
    spi_xfer(nwords, stop_after);
    check({tag, "/nwords"}, 32'(rcv_words.size()), 32'(exp_out.size()));
    for (int i = 0; i < exp_out.size() && i < rcv_words.size(); i++)
      check({tag, "/miso"}, rcv_words[i], exp_out[i]);
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    apb_read(8'h0C, d);
    check({tag, "/sts"}, d, {27'd0, m_und, m_ovr, m_tx_full, m_rv, 1'b0});
    check({tag, "/irq"}, {31'd0, irq},
          {31'd0, (m_rv & m_ie[0]) | (m_ovr & m_ie[1]) | (m_und & m_ie[2])});
    apb_read(8'h04, d);
    check({tag, "/tx_hold"}, d, m_tx_hold);
  endtask

  task automatic read_rx(input string tag);
    logic [31:0] d;
    apb_read(8'h08, d);
    check({tag, "/rx"}, d, m_rx);
    m_rv = 1'b0;
  endtask

  task automatic clear_sticky();
    apb_write(8'h0C, 32'h18);
    m_ovr = 1'b0; m_und = 1'b0;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          nw, ab, w;
    logic        cp, ch, ms, dotx;

    model_reset();
    c_cpol = 0; c_cpha = 0; c_msb = 1; c_w = 8;

    // Reset state
    repeat (3) @(negedge pclk);
    check("rst/miso_oe", {31'd0, spi_miso_oe}, 32'd0);
    check("rst/miso", {31'd0, spi_miso}, 32'd0);
    check("rst/irq", {31'd0, irq}, 32'd0);
    presetn = 1'b1;
    repeat (2) @(negedge pclk);
    apb_read(8'h00, d); check("rst/ctrl", d, 32'h0000_0708);
    check("rst/pready", {31'd0, last_rdy}, 32'd1);
    check("rst/pslverr_ok", {31'd0, last_err}, 32'd0);
    apb_read(8'h08, d); check("rst/rx", d, 32'd0);
    apb_read(8'h10, d); check("rst/ie", d, 32'd0);
    check_status("rst");
    apb_read(8'h14, d); check("slverr/0x14", {31'd0, last_err}, 32'd1);
    apb_read(8'hFC, d); check("slverr/0xfc", {31'd0, last_err}, 32'd1);

    // Mode 0, 8-bit MSB-first, rx_valid interrupt
    apb_write(8'h10, 32'h1); m_ie = 3'b001;
    apb_read(8'h10, d); check("ie/readback", d, 32'h1);
    tx_words = '{32'hA5};
    run_frame("m0", 0, 0, 1, 8, 1, 0, 1, 32'h3C);
    check("m0/miso_lit", rcv_words.size() > 0 ? rcv_words[0] : 32'hX, 32'h3C);
    check_status("m0");
    read_rx("m0");
    check("m0/rx_lit", m_rx, 32'hA5);
    check_status("m0_after_rd");

    // Mode 3, 16-bit LSB-first
    tx_words = '{32'hBEEF};
    run_frame("m3", 1, 1, 0, 16, 1, 0, 1, 32'h1234);
    check_status("m3");
    read_rx("m3");

    // Underrun: no TX write
    clear_sticky();
    tx_words = '{32'h69};
    run_frame("und", 0, 0, 1, 8, 1, 0, 0, 32'h0);
    check_status("und");
    apb_write(8'h0C, 32'h10); m_und = 1'b0;
    check_status("und_w1c");
    read_rx("und");

    // Overrun: two words without reading RX
    clear_sticky();
    tx_words = '{32'h11, 32'h22};
    run_frame("ovr", 0, 0, 1, 8, 2, 0, 1, 32'h77);
    check_status("ovr");
    read_rx("ovr");
    check("ovr/rx_lit", m_rx, 32'h22);

    // Abort after 5 bits, then a clean frame
    clear_sticky();
    tx_words = '{32'hFF};
    run_frame("abort", 0, 0, 1, 8, 1, 5, 1, 32'h81);
    check_status("abort");
    tx_words = '{32'h5A};
    run_frame("post_abort", 0, 0, 1, 8, 1, 0, 1, 32'h42);
    check_status("post_abort");
    read_rx("post_abort");

    // presetn pulse mid-word (mode 1), then a clean mode 1 frame
    c_cpol = 0; c_cpha = 1; c_msb = 1; c_w = 8;
    @(negedge pclk); spi_sclk = 1'b0;
    apb_write(8'h00, 32'h0000_0705);
    apb_write(8'h04, 32'hF0);
    @(negedge pclk); spi_cs_n = 1'b0;
    repeat (8) @(negedge pclk);
    for (int k = 0; k < 3; k++) begin
      spi_sclk = 1'b1; spi_mosi = 1'($urandom_range(0, 1));
      repeat (HALF) @(negedge pclk);
      spi_sclk = 1'b0;
      repeat (HALF) @(negedge pclk);
    end
    check("rst_mid/oe_busy", {31'd0, spi_miso_oe}, 32'd1);
    presetn = 1'b0;
    #1;
    check("rst_mid/oe", {31'd0, spi_miso_oe}, 32'd0);
    check("rst_mid/miso", {31'd0, spi_miso}, 32'd0);
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    model_reset();
    repeat (2) @(negedge pclk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge pclk);
    apb_read(8'h00, d); check("rst_mid/ctrl", d, 32'h0000_0708);
    check_status("rst_mid");
    tx_words = '{32'hC3};
    run_frame("m1", 0, 1, 1, 8, 1, 0, 1, $urandom);
    check_status("m1");
    read_rx("m1");
    check("m1/rx_lit", m_rx, 32'hC3);

    // Randomized frames
    for (int f = 0; f < 24; f++) begin
      cp = 1'($urandom_range(0, 1));
      ch = 1'($urandom_range(0, 1));
      ms = 1'($urandom_range(0, 1));
      w  = ($urandom_range(0, 3) == 0) ? 32 : int'($urandom_range(1, 32));
      nw = int'($urandom_range(1, 2));
      ab = (w >= 2 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, w - 1)) : 0;
      dotx = ($urandom_range(0, 3) != 0);
      m_ie = 3'($urandom_range(0, 7));
      apb_write(8'h10, {29'd0, m_ie});
      tx_words.delete();
      for (int i = 0; i < nw; i++) tx_words.push_back($urandom & wmask(w));
      run_frame("rnd", cp, ch, ms, w, nw, ab, dotx, $urandom);
      check_status("rnd");
      if ($urandom_range(0, 1) == 1) read_rx("rnd");
      if ($urandom_range(0, 1) == 1) begin
        d = {27'd0, 2'($urandom_range(0, 3)), 3'd0};
        apb_write(8'h0C, d);
        if (d[3]) m_ovr = 1'b0;
        if (d[4]) m_und = 1'b0;
        check_status("rnd_w1c");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
